// File: rtl/cnt_pkg.sv
// Shared definitions for the counter family: default width and the end-of-range
// mode selected by the SATURATE parameter.
package cnt_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_t;

endpackage : cnt_pkg

// File: rtl/incrementer8b.sv
// Combinational +1 incrementer built as a half-adder ripple chain;
// Carry is high exactly when A is all-ones.
module incrementer8b
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W_DEFAULT
) (
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] S,
    output logic             Carry
);

    logic [WIDTH:0] c;

    // Carry-in of 1 turns the half-adder chain into an incrementer
    assign c[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ha
        assign S[i]   = A[i] ^ c[i];
        assign c[i+1] = A[i] & c[i];
    end

    assign Carry = c[WIDTH];

endmodule : incrementer8b

// File: rtl/incrementer8b_counter.sv
// Registered up-counter with load, enable, wrap/saturate at MAX_VAL and a
// one-cycle carry pulse for chaining into wider counters.
module incrementer8b_counter
    import cnt_pkg::*;
#(
    parameter int unsigned     WIDTH    = CNT_W_DEFAULT,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry
);

    localparam cnt_mode_t MODE = SATURATE ? MODE_SAT : MODE_WRAP;

    logic [WIDTH-1:0] inc_s;
    logic             inc_carry;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH-1:0] load_clamped;
    logic             at_max;
    logic [WIDTH-1:0] count_d;
    logic             carry_d;

    incrementer8b #(
        .WIDTH (WIDTH)
    ) u_inc (
        .A     (count),
        .S     (inc_s),
        .Carry (inc_carry)
    );

    assign inc_sum      = {inc_carry, inc_s};
    assign at_max       = (count == MAX_VAL);
    assign tc           = at_max;
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Next-state mux: load beats enable; terminal count wraps or holds
    always_comb begin
        count_d = count;
        carry_d = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            if (at_max) begin
                carry_d = 1'b1;
                count_d = (MODE == MODE_SAT) ? MAX_VAL : '0;
            end else begin
                count_d = inc_sum[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            carry <= 1'b0;
        end else begin
            count <= count_d;
            carry <= carry_d;
        end
    end

    // With a full-range terminal the ripple carry-out must agree with the compare
    a_carry_matches_tc : assert property (@(posedge clk) disable iff (!rst_n)
        (MAX_VAL != {WIDTH{1'b1}}) || (inc_sum[WIDTH] == at_max));

endmodule : incrementer8b_counter

// File: tb/tb_incrementer8b_counter.sv
// Scoreboard bench for incrementer8b_counter: three instances (wrap/255,
// saturate/10, wrap/100) driven together and checked against a reference model.
module tb_incrementer8b_counter;

    localparam int unsigned N = 3;

    typedef struct packed {
        logic [N-1:0][7:0] cnt;
        logic [N-1:0]      cy;
    } exp_t;

    int max_v [N] = '{255, 10, 100};
    bit sat_v [N] = '{1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_s    [N];
    logic       load_s  [N];
    logic [7:0] lv_s    [N];
    logic [7:0] count_s [N];
    logic       tc_s    [N];
    logic       carry_s [N];

    int   ref_cnt [N];
    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   carry_seen0 = 0;

    always #5 clk = ~clk;

    incrementer8b_counter u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en_s[0]), .load(load_s[0]), .load_val(lv_s[0]),
        .count(count_s[0]), .tc(tc_s[0]), .carry(carry_s[0])
    );

    incrementer8b_counter #(.WIDTH(8), .MAX_VAL(8'd10), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en_s[1]), .load(load_s[1]), .load_val(lv_s[1]),
        .count(count_s[1]), .tc(tc_s[1]), .carry(carry_s[1])
    );

    incrementer8b_counter #(.WIDTH(8), .MAX_VAL(8'd100), .SATURATE(1'b0)) u_dut_clamp (
        .clk(clk), .rst_n(rst_n), .en(en_s[2]), .load(load_s[2]), .load_val(lv_s[2]),
        .count(count_s[2]), .tc(tc_s[2]), .carry(carry_s[2])
    );

    task automatic check(input string name, input int d, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, d, got, exp, $time);
        end
    endtask

    // Reference behaviour: load clamps, enable counts modulo (MAX+1) or sticks at MAX
    function automatic int model_next(input int d, input int cnt, input bit en,
                                      input bit ld, input int lv, output bit cy);
        cy = 1'b0;
        if (ld) return (lv > max_v[d]) ? max_v[d] : lv;
        if (!en) return cnt;
        cy = (cnt == max_v[d]);
        if (sat_v[d] && cy) return cnt;
        return (cnt + 1) % (max_v[d] + 1);
    endfunction

    // Record the expected result of the upcoming edge, then move to the next negedge
    task automatic tick();
        exp_t e;
        bit   c;
        e = '0;
        for (int d = 0; d < N; d++) begin
            ref_cnt[d] = model_next(d, ref_cnt[d], en_s[d] === 1'b1, load_s[d] === 1'b1,
                                    int'(lv_s[d]), c);
            e.cnt[d] = 8'(ref_cnt[d]);
            e.cy[d]  = c;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int d = 0; d < N; d++) begin
            en_s[d]   = 1'b0;
            load_s[d] = 1'b0;
            lv_s[d]   = 8'h00;
        end
    endtask

    task automatic load_one(input int d, input int v);
        idle_all();
        load_s[d] = 1'b1;
        lv_s[d]   = 8'(v);
        tick();
        idle_all();
    endtask

    task automatic en_one(input int d, input int cycles);
        idle_all();
        en_s[d] = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        idle_all();
    endtask

    // Monitor: outputs are always valid, so one expectation is consumed per edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int d = 0; d < N; d++) begin
                check("count", d, 32'(count_s[d]), 32'(e.cnt[d]));
                check("carry", d, 32'(carry_s[d]), 32'(e.cy[d]));
                check("tc",    d, 32'(tc_s[d]),    32'(int'(e.cnt[d]) == max_v[d]));
            end
            if (carry_s[0] === 1'b1) carry_seen0++;
        end
    end

    initial begin
        rst_n = 1'b0;
        idle_all();
        for (int d = 0; d < N; d++) ref_cnt[d] = 0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check("reset_count", d, 32'(count_s[d]), 32'd0);
            check("reset_carry", d, 32'(carry_s[d]), 32'd0);
        end
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a cycle clears 0x37 without an edge
        load_one(0, 8'h37);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 0, 32'(count_s[0]), 32'd0);
        check("async_rst_carry", 0, 32'(carry_s[0]), 32'd0);
        for (int d = 0; d < N; d++) begin
            ref_cnt[d] = 0;
            en_s[d]    = 1'bx;
            load_s[d]  = 1'bx;
        end
        repeat (2) @(negedge clk);
        check("rst_x_inputs", 0, 32'(count_s[0]), 32'd0);
        idle_all();
        rst_n = 1'b1;
        en_one(0, 1);

        // Wrap at 0xFF with carry on the wrapping edge only
        load_one(0, 8'hFE);
        en_one(0, 3);

        // Saturate at 10 with carry held while enabled
        load_one(1, 9);
        en_one(1, 3);

        // Load beats enable at terminal count
        load_one(0, 8'hFF);
        idle_all();
        load_s[0] = 1'b1;
        lv_s[0]   = 8'h05;
        en_s[0]   = 1'b1;
        tick();
        idle_all();

        // Clamp to MAX_VAL and hold
        load_one(2, 200);
        for (int i = 0; i < 5; i++) tick();

        // Sweep 512 edges from zero: exactly two wraps
        load_one(0, 0);
        @(posedge clk);
        #2;
        carry_seen0 = 0;
        @(negedge clk);
        en_one(0, 512);
        tick();
        @(posedge clk);
        #2;
        check("sweep_carry_pulses", 0, 32'(carry_seen0), 32'd2);

        // Random mix of load, enable and idle on all instances
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < N; d++) begin
                load_s[d] = 1'($urandom_range(0, 7) == 0);
                en_s[d]   = 1'($urandom_range(0, 3) != 0);
                lv_s[d]   = 8'($urandom_range(0, 255));
            end
            tick();
        end
        idle_all();
        tick();
        @(posedge clk);
        #2;
        check("queue_drained", 0, 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_incrementer8b_counter
